simplespislave: RTL and testbench

- SPI mode-0 target (slave) for the picorv32 iosys; the counterpart of the SPI master path.
- Lets an external SPI master (debug MCU, companion FPGA) exchange bytes with the CPU.
- Oversamples SCK/MOSI/CS_N in the clk domain, buffers received bytes in an RX FIFO, and serves transmit bytes from a one-byte TX holding register.
- CPU access is through the register strobes below, with a reg_wait stall on TX-full.

---
 rtl/simplespislave_pkg.sv | 20 ++
 rtl/simplespislave_if.sv | 21 ++
 rtl/simplespislave_spi_rx_fifo.sv | 58 +++++
 rtl/simplespislave.sv | 212 +++++++++++++++++++++
 tb/tb_simplespislave.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simplespislave_pkg.sv
// Shared constants for the SPI target slice: status bit layout, state encoding
// and the default idle/fill byte.
package simplespi_pkg;

   localparam int unsigned STAT_RXNE    = 0;
   localparam int unsigned STAT_OVR     = 1;
   localparam int unsigned STAT_UDR     = 2;
   localparam int unsigned STAT_TXF     = 3;
   localparam int unsigned STAT_CS      = 4;
   localparam int unsigned STAT_CNT_LSB = 8;

   localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

   typedef enum logic [1:0] {
      RESYNC,
      IDLE,
      XFER
   } spi_state_t;

endpackage

// File: rtl/simplespislave_if.sv
// CPU register-strobe bus of the SPI target; master = CPU side, slave = peripheral.
interface simplespislave_if;

   logic        reg_dat_we;
   logic        reg_dat_re;
   logic        reg_stat_re;
   logic [31:0] reg_di;
   logic [31:0] reg_do;
   logic        reg_wait;

   modport master (
      output reg_dat_we, reg_dat_re, reg_stat_re, reg_di,
      input  reg_do, reg_wait
   );

   modport slave (
      input  reg_dat_we, reg_dat_re, reg_stat_re, reg_di,
      output reg_do, reg_wait
   );

endinterface

// File: rtl/simplespislave_spi_rx_fifo.sv
// Byte FIFO for received SPI data; head is first-word-fall-through.
// A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
module spi_rx_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      pop_ok   = pop & ~empty;
      push_ok  = push & (~full | pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
      else if (!push_ok && pop_ok) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/simplespislave.sv
// SPI mode-0 target for the iosys: oversampled SCK/CS_N/MOSI, RX FIFO, one-byte TX holding.
// Optional RX interrupt output is enabled with `define SIMPLESPISLAVE_IRQ_EN.
module simplespislave
   import simplespi_pkg::*;
#(
   parameter int unsigned RX_DEPTH  = 8,
   parameter logic [7:0]  FILL_BYTE = FILL_BYTE_DEFAULT
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            sck,
   input  logic            cs_n,
   input  logic            mosi,
   output logic            miso,
   simplespislave_if.slave bus
`ifdef SIMPLESPISLAVE_IRQ_EN
   ,
   output logic            irq
`endif
);

   localparam int unsigned CW = $clog2(RX_DEPTH) + 1;

   // Synchroniser lanes ordered {sck, cs_n, mosi}; history only for sck and cs_n.
   logic [2:0] meta_q, sync_q;
   logic [1:0] hist_q;
   logic       sck_s, cs_s, mosi_s;
   logic       sck_rise, sck_fall, cs_rise, cs_fall;

   spi_state_t state_q, state_d;
   logic       frame_start, bit_in, bit_out, bitcnt_clr, tx_load;

   logic [7:0]  rx_shift_q, rx_shift_d, rx_byte;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_valid_q, hold_valid_d;
   logic        overrun_q, overrun_d;
   logic        underrun_q, underrun_d;
   logic [31:0] reg_do_q, reg_do_d;
   logic [31:0] stat_word;

   logic          rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]    rx_head;
   logic [CW-1:0] rx_count;
   logic          unused_di_hi;

   assign unused_di_hi = ^bus.reg_di[31:8];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta_q <= '0;
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         meta_q <= {sck, cs_n, mosi};
         sync_q <= meta_q;
         hist_q <= sync_q[2:1];
      end
   end

   assign sck_s    = sync_q[2];
   assign cs_s     = sync_q[1];
   assign mosi_s   = sync_q[0];
   assign sck_rise =  sck_s & ~hist_q[1];
   assign sck_fall = ~sck_s &  hist_q[1];
   assign cs_rise  =  cs_s  & ~hist_q[0];
   assign cs_fall  = ~cs_s  &  hist_q[0];

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= RESYNC;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RESYNC:  if (cs_s)    state_d = IDLE;
         IDLE:    if (cs_fall) state_d = XFER;
         XFER:    if (cs_rise) state_d = IDLE;
         default:              state_d = RESYNC;
      endcase
   end

   // cs_n deassertion outranks a coincident SCK edge, so the closing SCK fall
   // of a frame never triggers a byte-boundary reload.
   always_comb begin
      frame_start = 1'b0;
      bit_in      = 1'b0;
      bit_out     = 1'b0;
      bitcnt_clr  = 1'b1;
      unique case (state_q)
         IDLE: frame_start = cs_fall;
         XFER: begin
            bitcnt_clr = cs_rise;
            bit_in     = sck_rise & ~cs_rise;
            bit_out    = sck_fall & ~cs_rise;
         end
         default: ;
      endcase
   end

   assign rx_byte = {rx_shift_q[6:0], mosi_s};
   assign rx_push = bit_in & (bitcnt_q == 3'd7);
   assign rx_pop  = bus.reg_dat_re & ~bus.reg_stat_re & ~rx_empty;
   assign tx_load = frame_start | (bit_out & (bitcnt_q == 3'd0));

   spi_rx_fifo #(
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (rx_push),
      .push_data (rx_byte),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   always_comb begin
      stat_word                       = '0;
      stat_word[STAT_RXNE]            = ~rx_empty;
      stat_word[STAT_OVR]             = overrun_q;
      stat_word[STAT_UDR]             = underrun_q;
      stat_word[STAT_TXF]             = hold_valid_q;
      stat_word[STAT_CS]              = ~cs_s;
      stat_word[STAT_CNT_LSB +: 8]    = 8'(rx_count);
   end

   // Flag clears from a status read are applied first so a same-cycle event re-sets them.
   always_comb begin
      rx_shift_d   = rx_shift_q;
      bitcnt_d     = bitcnt_q;
      tx_shift_d   = tx_shift_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      overrun_d    = overrun_q  & ~bus.reg_stat_re;
      underrun_d   = underrun_q & ~bus.reg_stat_re;
      reg_do_d     = reg_do_q;

      if (bitcnt_clr) begin
         bitcnt_d = '0;
      end else if (bit_in) begin
         rx_shift_d = rx_byte;
         bitcnt_d   = bitcnt_q + 3'd1;
      end

      if (tx_load) begin
         if (hold_valid_q) begin
            tx_shift_d   = hold_q;
            hold_valid_d = 1'b0;
         end else begin
            tx_shift_d   = FILL_BYTE;
            underrun_d   = 1'b1;
         end
      end else if (bit_out) begin
         tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end

      if (bus.reg_dat_we && !hold_valid_q) begin
         hold_d       = bus.reg_di[7:0];
         hold_valid_d = 1'b1;
      end

      if (rx_push && rx_full && !rx_pop) overrun_d = 1'b1;

      if (bus.reg_stat_re)     reg_do_d = stat_word;
      else if (bus.reg_dat_re) reg_do_d = rx_empty ? '0 : {23'b0, 1'b1, rx_head};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_shift_q   <= '0;
         bitcnt_q     <= '0;
         tx_shift_q   <= FILL_BYTE;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         underrun_q   <= 1'b0;
         reg_do_q     <= '0;
      end else begin
         rx_shift_q   <= rx_shift_d;
         bitcnt_q     <= bitcnt_d;
         tx_shift_q   <= tx_shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         overrun_q    <= overrun_d;
         underrun_q   <= underrun_d;
         reg_do_q     <= reg_do_d;
      end
   end

   assign miso         = tx_shift_q[7];
   assign bus.reg_do   = reg_do_q;
   assign bus.reg_wait = bus.reg_dat_we & hold_valid_q;

`ifdef SIMPLESPISLAVE_IRQ_EN
   logic irq_q, irq_d;

   assign irq_d = ~rx_empty | overrun_q;

   always_ff @(posedge clk) begin
      if (!resetn) irq_q <= 1'b0;
      else         irq_q <= irq_d;
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_simplespislave.sv
// Bench for simplespislave: a mode-0 SPI master plus CPU strobes, checked against
// a queue-based model of the RX FIFO, TX holding register and sticky flags.
module tb_simplespislave;

   localparam int   DEPTH = 8;
   localparam logic [7:0] FILL = 8'hFF;
   localparam int   HALF  = 80;
   localparam int   TMO   = 3000;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic sck = 1'b0;
   logic cs_n = 1'b1;
   logic mosi = 1'b0;
   logic miso;
`ifdef SIMPLESPISLAVE_IRQ_EN
   logic irq;
`endif

   simplespislave_if bus ();

   simplespislave #(
      .RX_DEPTH  (DEPTH),
      .FILL_BYTE (FILL)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .sck    (sck),
      .cs_n   (cs_n),
      .mosi   (mosi),
      .miso   (miso),
      .bus    (bus)
`ifdef SIMPLESPISLAVE_IRQ_EN
      ,
      .irq    (irq)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0] m_rxq[$];
   logic [7:0] m_hold, m_pend;
   bit         m_hold_v, m_pend_v, m_ovr, m_udr;
   logic [7:0] mbytes[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_rxq.delete();
      m_hold_v = 1'b0;
      m_pend_v = 1'b0;
      m_ovr    = 1'b0;
      m_udr    = 1'b0;
   endtask

   // Byte the target must present at a frame start or byte boundary.
   task automatic m_next_tx(output logic [7:0] b);
      if (m_hold_v) begin
         b        = m_hold;
         m_hold   = m_pend;
         m_hold_v = m_pend_v;
         m_pend_v = 1'b0;
      end else begin
         b     = FILL;
         m_udr = 1'b1;
      end
   endtask

   task automatic m_push(input logic [7:0] b);
      if (m_rxq.size() < DEPTH) m_rxq.push_back(b);
      else                      m_ovr = 1'b1;
   endtask

   task automatic cpu_write(input logic [7:0] b);
      int waits;
      waits = 0;
      @(negedge clk);
      bus.reg_di     = {24'($urandom), b};
      bus.reg_dat_we = 1'b1;
      #1;
      while (bus.reg_wait === 1'b1 && waits < TMO) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (waits >= TMO) check_eq("write_stall_bound", 32'(bus.reg_wait), 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.reg_dat_we = 1'b0;
   endtask

   // mode 0: data read, 1: status read, 2: both strobes together
   task automatic cpu_read(input int mode, output logic [31:0] d);
      @(negedge clk);
      bus.reg_dat_re  = (mode != 1);
      bus.reg_stat_re = (mode != 0);
      @(negedge clk);
      bus.reg_dat_re  = 1'b0;
      bus.reg_stat_re = 1'b0;
      d = bus.reg_do;
   endtask

   task automatic expect_pop();
      logic [31:0] d, e;
      e = (m_rxq.size() != 0) ? {23'b0, 1'b1, m_rxq.pop_front()} : 32'd0;
      cpu_read(0, d);
      check_eq("pop", d, e);
   endtask

   task automatic expect_stat(input int mode);
      logic [31:0] d, e;
      logic        e_irq;
      e = {16'b0, 8'(m_rxq.size()), 3'b0, 1'b0, m_hold_v, m_udr, m_ovr, m_rxq.size() != 0};
      e_irq = (m_rxq.size() != 0) | m_ovr;
      cpu_read(mode, d);
      m_ovr = 1'b0;
      m_udr = 1'b0;
      check_eq("status", d, e);
`ifdef SIMPLESPISLAVE_IRQ_EN
      check_eq("irq", 32'(irq), 32'(e_irq));
`else
      if (e_irq) ;
`endif
   endtask

   task automatic spi_bit(input logic mo, output logic mi);
      sck  = 1'b0;
      mosi = mo;
      #HALF;
      mi  = miso;
      sck = 1'b1;
      #HALF;
   endtask

   task automatic spi_frame(input int nbits);
      logic [7:0] cur, exp_b, got_b;
      logic       mi;
      cur = '0; exp_b = '0; got_b = '0;
      cs_n = 1'b0;
      for (int k = 0; k < nbits; k++) begin
         if (k % 8 == 0) begin
            m_next_tx(exp_b);
            cur = mbytes[k / 8];
         end
         spi_bit(cur[7 - (k % 8)], mi);
         got_b = {got_b[6:0], mi};
         if (k % 8 == 7) begin
            check_eq("miso_byte", 32'(got_b), 32'(exp_b));
            m_push(cur);
         end
      end
      sck  = 1'b0;
      cs_n = 1'b1;
      #(4*HALF);
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic        mi;
      int          nb, nbits, npop;

      bus.reg_dat_we  = 1'b0;
      bus.reg_dat_re  = 1'b0;
      bus.reg_stat_re = 1'b0;
      bus.reg_di      = '0;
      m_reset();

      // Reset state
      repeat (4) @(negedge clk);
      check_eq("rst_miso", 32'(miso), 32'(FILL[7]));
      check_eq("rst_reg_do", bus.reg_do, 32'd0);
      check_eq("rst_reg_wait", 32'(bus.reg_wait), 32'd0);
      resetn = 1'b1;
      repeat (6) @(negedge clk);
      expect_stat(1);

      // Transmit 0xA5 while receiving 0x3C
      cpu_write(8'hA5);
      m_hold = 8'hA5; m_hold_v = 1'b1;
      mbytes = '{8'h3C};
      spi_frame(8);
      expect_stat(2);
      expect_pop();
      expect_stat(1);

      // Underrun: two bytes with nothing written
      mbytes = '{8'h5A, 8'hC3};
      spi_frame(16);
      expect_stat(1);
      expect_stat(1);
      expect_pop();
      expect_pop();

      // Overrun: nine bytes into an eight-deep FIFO
      mbytes.delete();
      for (int i = 0; i < 9; i++) mbytes.push_back(8'(i));
      spi_frame(72);
      expect_stat(1);
      for (int i = 0; i < 9; i++) expect_pop();

      // TX stall: second write waits for the first byte to be consumed
      m_hold = 8'h11; m_hold_v = 1'b1;
      m_pend = 8'h22; m_pend_v = 1'b1;
      mbytes = '{8'($urandom), 8'($urandom)};
      fork
         begin
            cpu_write(8'h11);
            cpu_write(8'h22);
         end
         begin
            repeat (30) @(negedge clk);
            #1;
            check_eq("reg_wait_stall", 32'(bus.reg_wait), 32'd1);
            @(negedge clk);
            spi_frame(16);
         end
      join
      expect_stat(1);
      expect_pop();
      expect_pop();

      // Abort after 5 bits, then a clean frame realigns
      mbytes = '{8'hE7};
      spi_frame(5);
      expect_stat(1);
      mbytes = '{8'h96};
      spi_frame(8);
      expect_pop();
      expect_stat(1);

      // Reset while cs_n is low: that frame must be ignored
      @(negedge clk);
      cs_n = 1'b0;
      for (int i = 0; i < 3; i++) spi_bit(1'($urandom), mi);
      @(negedge clk);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      m_reset();
      for (int i = 0; i < 16; i++) spi_bit(1'($urandom), mi);
      sck  = 1'b0;
      cs_n = 1'b1;
      #(4*HALF);
      expect_stat(1);
      mbytes = '{8'h4B};
      spi_frame(8);
      expect_pop();

      // Randomised frames, writes and pops
      for (int it = 0; it < 10; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            m_hold = 8'($urandom);
            m_hold_v = 1'b1;
            cpu_write(m_hold);
         end
         nb = $urandom_range(1, 3);
         nbits = nb * 8 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
         mbytes.delete();
         for (int i = 0; i <= nb; i++) mbytes.push_back(8'($urandom));
         spi_frame(nbits);
         npop = $urandom_range(0, 3);
         for (int i = 0; i < npop; i++) expect_pop();
         expect_stat(($urandom_range(0, 3) == 0) ? 2 : 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
